// File: rtl/signed_mon_pkg.sv
// Shared types and helpers for the signed level monitor.
// Optional build macro: LEVEL_MON_CROSS_COUNT_EN (adds a saturating crossing counter).
package signed_mon_pkg;

    localparam int WIDTH_DEFAULT = 8;
    localparam int HYST_DEFAULT  = 2;
    localparam int MAX_W         = 32;

    typedef enum logic [1:0] {
        ZONE_INIT = 2'b00,
        ZONE_LOW  = 2'b01,
        ZONE_MID  = 2'b10,
        ZONE_HIGH = 2'b11
    } zone_e;

    // Sign-extend the low w bits of v across the full MAX_W word.
    function automatic logic [MAX_W-1:0] sign_extend(input logic [MAX_W-1:0] v,
                                                     input int unsigned     w);
        logic [MAX_W-1:0] r;
        r = v;
        for (int unsigned i = w; i < MAX_W; i++) begin
            r[i] = v[w-1];
        end
        return r;
    endfunction

endpackage

// File: rtl/signed_minmax_tracker.sv
// Running signed minimum/maximum of qualified samples since reset or clear.
module signed_minmax_tracker
    import signed_mon_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             valid,
    input  logic [WIDTH-1:0] sample,
    output logic [WIDTH-1:0] min_q,
    output logic [WIDTH-1:0] max_q,
    output logic             stats_valid
);

    logic signed [WIDTH-1:0] s_sample;
    logic signed [WIDTH-1:0] s_min;
    logic signed [WIDTH-1:0] s_max;

    assign s_sample = sample;
    assign s_min    = min_q;
    assign s_max    = max_q;

    // Clear dominates; the first sample loads both extremes, later ones widen them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_q       <= '0;
            max_q       <= '0;
            stats_valid <= 1'b0;
        end else if (clr) begin
            min_q       <= '0;
            max_q       <= '0;
            stats_valid <= 1'b0;
        end else if (valid) begin
            stats_valid <= 1'b1;
            if (!stats_valid) begin
                min_q <= sample;
                max_q <= sample;
            end else begin
                if (s_sample < s_min) min_q <= sample;
                if (s_sample > s_max) max_q <= sample;
            end
        end
    end

endmodule

// File: rtl/signed_level_monitor.sv
// Signed level monitor: classifies samples into LOW/MID/HIGH zones with
// hysteresis, pulses on crossings and tracks running min/max.
// Optional build macro: LEVEL_MON_CROSS_COUNT_EN adds port cross_cnt.
module signed_level_monitor
    import signed_mon_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int HYST  = HYST_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] sample,
    input  logic [WIDTH-1:0] lo_th,
    input  logic [WIDTH-1:0] hi_th,
    output logic [1:0]       zone,
    output logic             cross_up,
    output logic             cross_dn,
    output logic [WIDTH-1:0] min_q,
    output logic [WIDTH-1:0] max_q,
    output logic             stats_valid,
`ifdef LEVEL_MON_CROSS_COUNT_EN
    output logic [7:0]       cross_cnt,
`endif
    output logic             cfg_err
);

    localparam int BW = WIDTH + 2;

    zone_e zone_q;
    zone_e zone_next;
    logic  up_next;
    logic  dn_next;
    logic  cfg_err_next;

    logic signed [BW-1:0] smp_ext;
    logic signed [BW-1:0] lo_ext;
    logic signed [BW-1:0] hi_ext;
    logic signed [BW-1:0] lo_bound;
    logic signed [BW-1:0] hi_bound;

    // Two extra bits keep the hysteresis bounds from wrapping at the range ends.
    assign smp_ext  = BW'(sign_extend(MAX_W'(sample), WIDTH));
    assign lo_ext   = BW'(sign_extend(MAX_W'(lo_th),  WIDTH));
    assign hi_ext   = BW'(sign_extend(MAX_W'(hi_th),  WIDTH));
    assign lo_bound = lo_ext + BW'(HYST);
    assign hi_bound = hi_ext - BW'(HYST);

    assign cfg_err_next = (lo_ext >= hi_ext);
    assign zone         = zone_q;

    // Next-zone and crossing-pulse decode for the current sample.
    always_comb begin
        zone_next = zone_q;
        up_next   = 1'b0;
        dn_next   = 1'b0;
        if (sample_valid && !cfg_err_next) begin
            unique case (zone_q)
                ZONE_INIT: begin
                    if (smp_ext >= hi_ext)      zone_next = ZONE_HIGH;
                    else if (smp_ext <= lo_ext) zone_next = ZONE_LOW;
                    else                        zone_next = ZONE_MID;
                end
                ZONE_MID: begin
                    if (smp_ext >= hi_ext) begin
                        zone_next = ZONE_HIGH;
                        up_next   = 1'b1;
                    end else if (smp_ext <= lo_ext) begin
                        zone_next = ZONE_LOW;
                        dn_next   = 1'b1;
                    end
                end
                ZONE_HIGH: begin
                    if (smp_ext < hi_bound) begin
                        if (smp_ext <= lo_ext) begin
                            zone_next = ZONE_LOW;
                            dn_next   = 1'b1;
                        end else begin
                            zone_next = ZONE_MID;
                        end
                    end
                end
                ZONE_LOW: begin
                    if (smp_ext > lo_bound) begin
                        if (smp_ext >= hi_ext) begin
                            zone_next = ZONE_HIGH;
                            up_next   = 1'b1;
                        end else begin
                            zone_next = ZONE_MID;
                        end
                    end
                end
                default: zone_next = ZONE_INIT;
            endcase
        end
    end

    // Zone state, registered pulses and the config check (which ignores clr).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zone_q   <= ZONE_INIT;
            cross_up <= 1'b0;
            cross_dn <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            cfg_err <= cfg_err_next;
            if (clr) begin
                zone_q   <= ZONE_INIT;
                cross_up <= 1'b0;
                cross_dn <= 1'b0;
            end else begin
                zone_q   <= zone_next;
                cross_up <= up_next;
                cross_dn <= dn_next;
            end
        end
    end

`ifdef LEVEL_MON_CROSS_COUNT_EN
    // Saturating count of issued crossing pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cross_cnt <= '0;
        end else if (clr) begin
            cross_cnt <= '0;
        end else if ((up_next || dn_next) && (cross_cnt != 8'hFF)) begin
            cross_cnt <= cross_cnt + 8'd1;
        end
    end
`endif

    signed_minmax_tracker #(
        .WIDTH (WIDTH)
    ) u_minmax (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .valid       (sample_valid),
        .sample      (sample),
        .min_q       (min_q),
        .max_q       (max_q),
        .stats_valid (stats_valid)
    );

endmodule

// File: tb/tb_signed_level_monitor.sv
// Directed self-checking bench for signed_level_monitor (WIDTH=8, HYST=2).
module tb_signed_level_monitor;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       sample_valid;
    logic [7:0] sample;
    logic [7:0] lo_th;
    logic [7:0] hi_th;
    logic [1:0] zone;
    logic       cross_up;
    logic       cross_dn;
    logic [7:0] min_q;
    logic [7:0] max_q;
    logic       stats_valid;
    logic       cfg_err;
`ifdef LEVEL_MON_CROSS_COUNT_EN
    logic [7:0] cross_cnt;
`endif

    int total;
    int bad;

    signed_level_monitor #(
        .WIDTH (8),
        .HYST  (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .sample_valid (sample_valid),
        .sample       (sample),
        .lo_th        (lo_th),
        .hi_th        (hi_th),
        .zone         (zone),
        .cross_up     (cross_up),
        .cross_dn     (cross_dn),
        .min_q        (min_q),
        .max_q        (max_q),
        .stats_valid  (stats_valid),
`ifdef LEVEL_MON_CROSS_COUNT_EN
        .cross_cnt    (cross_cnt),
`endif
        .cfg_err      (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, sample just after the rising edge.
    task automatic step(input logic v, input logic [7:0] s, input logic c);
        @(negedge clk);
        sample_valid = v;
        sample       = s;
        clr          = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zp(input string tag, input logic [1:0] z, input logic up, input logic dn);
        chk({tag, "_zone"}, {6'b0, zone}, {6'b0, z});
        chk({tag, "_up"},   {7'b0, cross_up}, {7'b0, up});
        chk({tag, "_dn"},   {7'b0, cross_dn}, {7'b0, dn});
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        rst_n        = 1'b0;
        clr          = 1'b0;
        sample_valid = 1'b0;
        sample       = '0;
        lo_th        = 8'(-10);
        hi_th        = 8'd20;

        // Reset state
        #12;
        chk_zp("rst", 2'b00, 1'b0, 1'b0);
        chk("rst_min", min_q, 8'd0);
        chk("rst_max", max_q, 8'd0);
        chk("rst_sv", {7'b0, stats_valid}, 8'd0);
        chk("rst_cfg", {7'b0, cfg_err}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // First classification, then a crossing into HIGH
        step(1'b1, 8'd0, 1'b0);
        chk_zp("first", 2'b10, 1'b0, 1'b0);
        chk("first_sv", {7'b0, stats_valid}, 8'd1);
        step(1'b1, 8'd25, 1'b0);
        chk_zp("up25", 2'b11, 1'b1, 1'b0);
        chk("up25_min", min_q, 8'd0);
        chk("up25_max", max_q, 8'd25);
        step(1'b0, 8'd0, 1'b0);
        chk_zp("idle", 2'b11, 1'b0, 1'b0);

        // Hysteresis around hi_th-2 = 18
        step(1'b1, 8'd25, 1'b0);
        chk_zp("hy25", 2'b11, 1'b0, 1'b0);
        step(1'b1, 8'd19, 1'b0);
        chk_zp("hy19", 2'b11, 1'b0, 1'b0);
        step(1'b1, 8'd18, 1'b0);
        chk_zp("hy18", 2'b11, 1'b0, 1'b0);
        step(1'b1, 8'd17, 1'b0);
        chk_zp("hy17", 2'b10, 1'b0, 1'b0);

        // Back to HIGH, then direct jump to LOW
        step(1'b1, 8'd25, 1'b0);
        chk_zp("re25", 2'b11, 1'b1, 1'b0);
        step(1'b1, 8'(-50), 1'b0);
        chk_zp("jmp", 2'b01, 1'b0, 1'b1);
        chk("jmp_min", min_q, 8'(-50));

        // Range-end thresholds: bounds must not wrap
        lo_th = 8'(-128);
        hi_th = 8'd127;
        step(1'b1, 8'd127, 1'b0);
        chk_zp("w127", 2'b11, 1'b1, 1'b0);
        chk("w127_max", max_q, 8'd127);
        step(1'b1, 8'd125, 1'b0);
        chk_zp("w125", 2'b11, 1'b0, 1'b0);
        step(1'b1, 8'(-128), 1'b0);
        chk_zp("wm128", 2'b01, 1'b0, 1'b1);
        chk("wm128_min", min_q, 8'(-128));
        step(1'b1, 8'(-126), 1'b0);
        chk_zp("wm126", 2'b01, 1'b0, 1'b0);
        chk("w_cfg", {7'b0, cfg_err}, 8'd0);

        // clr beats a simultaneous sample
        step(1'b1, 8'd5, 1'b1);
        chk_zp("clr", 2'b00, 1'b0, 1'b0);
        chk("clr_sv", {7'b0, stats_valid}, 8'd0);
        chk("clr_min", min_q, 8'd0);
        chk("clr_max", max_q, 8'd0);

        // Config error: zone holds, stats still track
        lo_th = 8'd30;
        hi_th = 8'd20;
        step(1'b1, 8'd100, 1'b0);
        chk("ce_flag", {7'b0, cfg_err}, 8'd1);
        chk_zp("ce100", 2'b00, 1'b0, 1'b0);
        chk("ce100_sv", {7'b0, stats_valid}, 8'd1);
        step(1'b1, 8'(-100), 1'b0);
        chk_zp("cem100", 2'b00, 1'b0, 1'b0);
        chk("ce_min", min_q, 8'(-100));
        chk("ce_max", max_q, 8'd100);
        lo_th = 8'd20;
        step(1'b0, 8'd0, 1'b0);
        chk("ce_equal", {7'b0, cfg_err}, 8'd1);
        lo_th = 8'(-10);
        step(1'b0, 8'd0, 1'b0);
        chk("ce_clear", {7'b0, cfg_err}, 8'd0);
        chk_zp("ce_hold", 2'b00, 1'b0, 1'b0);
        step(1'b1, 8'd50, 1'b0);
        chk_zp("init_hi", 2'b11, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        chk_zp("arst", 2'b00, 1'b0, 1'b0);
        chk("arst_sv", {7'b0, stats_valid}, 8'd0);
        chk("arst_max", max_q, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef LEVEL_MON_CROSS_COUNT_EN
        chk("cnt_rst", cross_cnt, 8'd0);
        step(1'b1, 8'd50, 1'b0);
        step(1'b1, 8'(-50), 1'b0);
        step(1'b1, 8'd50, 1'b0);
        chk("cnt_two", cross_cnt, 8'd2);
        for (int i = 0; i < 298; i++) begin
            step(1'b1, (i % 2 == 0) ? 8'(-50) : 8'd50, 1'b0);
        end
        chk("cnt_sat", cross_cnt, 8'd255);
        step(1'b1, 8'd5, 1'b1);
        chk("cnt_clr", cross_cnt, 8'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
